// File: rtl/reset_seq_pkg.sv
// Shared types, default timing values and counter sizing for the reset sequencer.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        S_HOLD,
        S_MEM_INIT,
        S_STAGE,
        S_RUN,
        S_ERROR
    } state_t;

    localparam int unsigned DEF_POWERUP_CYCLES = 5000;
    localparam int unsigned DEF_NUM_STAGES     = 3;
    localparam int unsigned DEF_STAGE_GAP      = 16;
    localparam int unsigned DEF_INIT_TIMEOUT   = 65535;
    localparam int unsigned DEF_MAX_RETRIES    = 3;

    // Width that holds the largest of three counts, with one spare bit.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return 32'($clog2(m)) + 32'd1;
    endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Loadable saturating down-counter with a registered zero flag; shared by the
// power-up hold, inter-stage gap and init-timeout phases.
module reset_seq_timer #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= WIDTH'(RESET_VALUE);
            zero  <= (RESET_VALUE == 0);
        end else if (load) begin
            count <= load_value;
            zero  <= (load_value == '0);
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
            zero  <= (count == WIDTH'(1));
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Ordered release of subsystem resets: memory controller first, with init
// handshake and timeout. Optional init retry enabled by RESET_SEQ_RETRY_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES = DEF_POWERUP_CYCLES,
    parameter int unsigned NUM_STAGES     = DEF_NUM_STAGES,
    parameter int unsigned STAGE_GAP      = DEF_STAGE_GAP,
    parameter int unsigned INIT_TIMEOUT   = DEF_INIT_TIMEOUT
`ifdef RESET_SEQ_RETRY_EN
    ,
    parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES
`endif
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  mem_init_done,
    input  logic                  soft_reset_req,
    output logic [NUM_STAGES-1:0] stage_reset_n,
    output logic                  mem_init_start,
    output logic                  seq_ready,
    output logic                  seq_error
);

    localparam int unsigned CW = cnt_width(POWERUP_CYCLES, INIT_TIMEOUT, STAGE_GAP);
    // The timer fires on the edge where it already reads zero, so loads are N-1.
    localparam logic [CW-1:0] GAP_LOAD     = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(INIT_TIMEOUT - 1);

    state_t                state, state_next;
    logic [NUM_STAGES-1:0] stage_next;
    logic                  start_next, ready_next, error_next;
    logic                  start_pending, pending_next;
    logic                  tmr_load, tmr_enable, tmr_zero;
    logic [CW-1:0]         tmr_value;
    logic                  retry_ok;

`ifdef RESET_SEQ_RETRY_EN
    localparam int unsigned RW = cnt_width(MAX_RETRIES, 1, 1);
    logic [RW-1:0] retry_cnt, retry_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) retry_cnt <= '0;
        else          retry_cnt <= retry_next;
    end
`endif

    reset_seq_timer #(
        .WIDTH       (CW),
        .RESET_VALUE (POWERUP_CYCLES - 1)
    ) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .load_value (tmr_value),
        .enable     (tmr_enable),
        .zero       (tmr_zero)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_HOLD;
            stage_reset_n  <= '0;
            mem_init_start <= 1'b0;
            seq_ready      <= 1'b0;
            seq_error      <= 1'b0;
            start_pending  <= 1'b0;
        end else begin
            state          <= state_next;
            stage_reset_n  <= stage_next;
            mem_init_start <= start_next;
            seq_ready      <= ready_next;
            seq_error      <= error_next;
            start_pending  <= pending_next;
        end
    end

    always_comb begin
        state_next   = state;
        stage_next   = stage_reset_n;
        start_next   = 1'b0;
        ready_next   = seq_ready;
        error_next   = seq_error;
        pending_next = start_pending;
        tmr_load     = 1'b0;
        tmr_value    = '0;
        tmr_enable   = 1'b1;
        retry_ok     = 1'b0;
`ifdef RESET_SEQ_RETRY_EN
        retry_ok     = (retry_cnt < RW'(MAX_RETRIES));
        retry_next   = retry_cnt;
`endif

        case (state)
            S_HOLD: begin
                if (tmr_zero) begin
                    stage_next[0] = 1'b1;
                    pending_next  = 1'b1;
                    state_next    = S_MEM_INIT;
                end
            end

            S_MEM_INIT: begin
                // First cycle only issues the start pulse; done is sampled afterwards.
                if (start_pending) begin
                    start_next   = 1'b1;
                    pending_next = 1'b0;
                    tmr_load     = 1'b1;
                    tmr_value    = TIMEOUT_LOAD;
                end else if (mem_init_done) begin
                    tmr_load   = 1'b1;
                    tmr_value  = GAP_LOAD;
                    state_next = S_STAGE;
                end else if (tmr_zero) begin
                    stage_next = '0;
                    if (retry_ok) begin
`ifdef RESET_SEQ_RETRY_EN
                        retry_next = retry_cnt + RW'(1);
`endif
                        tmr_load   = 1'b1;
                        tmr_value  = GAP_LOAD;
                        state_next = S_HOLD;
                    end else begin
                        error_next = 1'b1;
                        state_next = S_ERROR;
                    end
                end
            end

            S_STAGE: begin
                // Stages release strictly in ascending order by shifting in ones.
                if (tmr_zero) begin
                    stage_next = {stage_reset_n[NUM_STAGES-2:0], 1'b1};
                    tmr_load   = 1'b1;
                    tmr_value  = GAP_LOAD;
                    if (&stage_next) begin
                        ready_next = 1'b1;
                        state_next = S_RUN;
`ifdef RESET_SEQ_RETRY_EN
                        retry_next = '0;
`endif
                    end
                end
            end

            S_RUN: begin
                tmr_enable = 1'b0;
                if (soft_reset_req) begin
                    stage_next = '0;
                    ready_next = 1'b0;
                    tmr_load   = 1'b1;
                    tmr_value  = GAP_LOAD;
                    state_next = S_HOLD;
                end
            end

            S_ERROR: begin
                tmr_enable = 1'b0;
            end

            default: begin
                state_next = S_HOLD;
            end
        endcase
    end

endmodule
